oc8051_param_cxrom: RTL and testbench

//  Parametrised, loadable code-ROM model for the 8051 core and secure-boot checks. After reset
//  a boot image is streamed in byte-serially; fetches are then served via req/ack with

---
 rtl/oc8051_param_cxrom_pkg.sv | 23 ++
 rtl/oc8051_param_cxrom_if.sv | 39 +++
 rtl/oc8051_param_cxrom_fetch_ctl.sv | 76 +++++++
 rtl/oc8051_param_cxrom.sv | 95 +++++++++
 tb/tb_oc8051_param_cxrom.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oc8051_param_cxrom_pkg.sv
// Shared types and constants for the loadable 8051 code ROM.
// Fetch FSM states, default fill byte and wait-state limits.
package oc8051_cxrom_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN_IDLE,
    ST_RUN_WAIT,
    ST_RUN_ACK
  } cxrom_state_e;

  localparam logic [7:0] CXROM_FILL = 8'h00;
  localparam int CXROM_MAX_WAIT = 3;
  localparam int CXROM_CNT_W = $clog2(CXROM_MAX_WAIT + 1);

  function automatic logic in_image(
    input logic [31:0] addr,
    input int unsigned depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/oc8051_param_cxrom_if.sv
// Load stream and fetch request/ack bus of the code ROM.
// master drives the image and requests, slave answers.
interface oc8051_param_cxrom_if #(
  parameter int ADDR_W      = 16,
  parameter int FETCH_BYTES = 4
);

  logic                     ld_valid;
  logic [7:0]               ld_data;
  logic                     ld_last;
  logic                     ld_ready;
  logic                     rd_req;
  logic [ADDR_W-1:0]        cxrom_addr;
  logic                     rd_ack;
  logic [8*FETCH_BYTES-1:0] cxrom_data_out;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    output rd_req,
    output cxrom_addr,
    input  ld_ready,
    input  rd_ack,
    input  cxrom_data_out
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    input  rd_req,
    input  cxrom_addr,
    output ld_ready,
    output rd_ack,
    output cxrom_data_out
  );

endinterface

// File: rtl/oc8051_param_cxrom_fetch_ctl.sv
// Fetch sequencer: load/run state, wait counter, address capture.
// cap strobes the cycle the parent must register the fetch word.
module oc8051_cxrom_fetch_ctl
  import oc8051_cxrom_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] cxrom_addr,
  output cxrom_state_e      state,
  output logic [ADDR_W-1:0] addr_q,
  output logic              cap,
  output logic              rd_ack
);

  localparam logic [CXROM_CNT_W-1:0] WAIT_CNT =
    CXROM_CNT_W'(WAIT_STATES);

  cxrom_state_e           state_d;
  logic [CXROM_CNT_W-1:0] cnt_q;
  logic [CXROM_CNT_W-1:0] cnt_d;
  logic [ADDR_W-1:0]      addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_LOAD;
      cnt_q  <= '0;
      addr_q <= '0;
      rd_ack <= 1'b0;
    end else begin
      state  <= state_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      rd_ack <= cap;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cap     = 1'b0;
    unique case (state)
      ST_LOAD: begin
        // a request racing the last byte waits for RUN_IDLE
        if (load_done) state_d = ST_RUN_IDLE;
      end
      ST_RUN_IDLE: begin
        if (rd_req) begin
          addr_d  = cxrom_addr;
          cnt_d   = WAIT_CNT;
          state_d = ST_RUN_WAIT;
        end
      end
      ST_RUN_WAIT: begin
        if (cnt_q == '0) begin
          cap     = 1'b1;
          state_d = ST_RUN_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN_ACK: begin
        state_d = ST_RUN_IDLE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

endmodule

// File: rtl/oc8051_param_cxrom.sv
// Loadable code ROM: byte-serial boot image, wait-stated
// multi-byte fetches and a combinational opcode peek.
module oc8051_param_cxrom
  import oc8051_cxrom_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         ADDR_W      = 16,
  parameter int         FETCH_BYTES = 4,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] FILL        = CXROM_FILL
) (
  input  logic                 clk,
  input  logic                 rst,
  oc8051_param_cxrom_if.slave  bus,
  output logic                 loaded,
  input  logic [ADDR_W-1:0]    pc1,
  output logic                 op_valid,
  output logic [7:0]           op_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [7:0]               mem [DEPTH];
  logic [PTR_W-1:0]         wptr;
  cxrom_state_e             state;
  logic [ADDR_W-1:0]        addr_q;
  logic                     cap;
  logic                     ld_we;
  logic                     load_done;
  logic [8*FETCH_BYTES-1:0] word;

  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    return in_image(32'(a), DEPTH);
  endfunction

  assign ld_we     = (state == ST_LOAD) && bus.ld_valid;
  assign load_done = ld_we &&
                     (bus.ld_last || wptr == LAST_PTR);
  assign bus.ld_ready = (state == ST_LOAD) && !rst;
  assign loaded    = (state != ST_LOAD);
  assign op_valid  = loaded;
  assign op_out    = in_range(pc1) ?
                     mem[pc1[PTR_W-1:0]] : FILL;

  oc8051_cxrom_fetch_ctl #(
    .ADDR_W      (ADDR_W),
    .WAIT_STATES (WAIT_STATES)
  ) u_fetch_ctl (
    .clk        (clk),
    .rst        (rst),
    .load_done  (load_done),
    .rd_req     (bus.rd_req),
    .cxrom_addr (bus.cxrom_addr),
    .state      (state),
    .addr_q     (addr_q),
    .cap        (cap),
    .rd_ack     (bus.rd_ack)
  );

  // each fetch byte wraps independently at 2^ADDR_W
  for (genvar g = 0; g < FETCH_BYTES; g++) begin : g_byte
    logic [ADDR_W-1:0] a;
    assign a = addr_q + ADDR_W'(g);
    assign word[8*g +: 8] = in_range(a) ?
                            mem[a[PTR_W-1:0]] : FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL;
    end else if (ld_we) begin
      mem[wptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (ld_we) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cxrom_data_out <= '0;
    end else if (cap) begin
      bus.cxrom_data_out <= word;
    end
  end

endmodule

// File: tb/tb_oc8051_param_cxrom.sv
// Scoreboard bench: two ROMs (0 and 2 wait states) checked
// against a byte-image model on every rd_ack.
module tb_oc8051_param_cxrom;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acks [2];

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [7:0]  mdl [2][16];
  int          wp [2];
  bit          mdl_ld [2];

  logic        loaded_a, op_valid_a;
  logic [7:0]  op_out_a;
  logic [15:0] pc1_a;
  logic        loaded_b, op_valid_b;
  logic [7:0]  op_out_b;
  logic [15:0] pc1_b;

  oc8051_param_cxrom_if #(.ADDR_W(16), .FETCH_BYTES(4)) bus_a ();
  oc8051_param_cxrom_if #(.ADDR_W(16), .FETCH_BYTES(4)) bus_b ();

  oc8051_param_cxrom #(
    .DEPTH(16), .ADDR_W(16), .FETCH_BYTES(4),
    .WAIT_STATES(0), .FILL(8'h00)
  ) u_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .loaded(loaded_a), .pc1(pc1_a),
    .op_valid(op_valid_a), .op_out(op_out_a)
  );

  oc8051_param_cxrom #(
    .DEPTH(16), .ADDR_W(16), .FETCH_BYTES(4),
    .WAIT_STATES(2), .FILL(8'h00)
  ) u_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .loaded(loaded_b), .pc1(pc1_b),
    .op_valid(op_valid_b), .op_out(op_out_b)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(int s,
                                           logic [15:0] a);
    logic [31:0] w;
    logic [15:0] x;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      x = a + 16'(i);
      if (x < 16) w[8*i +: 8] = mdl[s][x[3:0]];
    end
    return w;
  endfunction

  function automatic logic ack_of(int s);
    return (s == 0) ? bus_a.rd_ack : bus_b.rd_ack;
  endfunction

  always @(posedge clk) begin
    #1;
    if (bus_a.rd_ack === 1'b1) begin
      acks[0]++;
      if (exp_q0.size() == 0)
        chk("ack_a_unexp", 32'(bus_a.rd_ack), 0);
      else
        chk("data_a", bus_a.cxrom_data_out,
            exp_q0.pop_front());
    end
    if (bus_b.rd_ack === 1'b1) begin
      acks[1]++;
      if (exp_q1.size() == 0)
        chk("ack_b_unexp", 32'(bus_b.rd_ack), 0);
      else
        chk("data_b", bus_b.cxrom_data_out,
            exp_q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) mdl[s][i] = 8'h00;
      wp[s] = 0;
      mdl_ld[s] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic idle_inputs();
    bus_a.ld_valid = 0; bus_a.ld_data = 0;
    bus_a.ld_last = 0; bus_a.rd_req = 0;
    bus_a.cxrom_addr = 0;
    bus_b.ld_valid = 0; bus_b.ld_data = 0;
    bus_b.ld_last = 0; bus_b.rd_req = 0;
    bus_b.cxrom_addr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_loaded", 32'(loaded_a), 0);
    chk("rst_ack", 32'(bus_a.rd_ack), 0);
    chk("rst_data", bus_a.cxrom_data_out, 0);
    rst = 1'b0;
    #1;
    chk("rst_ld_ready", 32'(bus_a.ld_ready), 1);
  endtask

  task automatic drive_ld(int s, logic [7:0] d, logic last);
    if (s == 0) begin
      bus_a.ld_valid = 1; bus_a.ld_data = d;
      bus_a.ld_last = last;
    end else begin
      bus_b.ld_valid = 1; bus_b.ld_data = d;
      bus_b.ld_last = last;
    end
    if (!mdl_ld[s]) begin
      mdl[s][wp[s]] = d;
      wp[s]++;
      if (last || wp[s] == 16) mdl_ld[s] = 1'b1;
    end
  endtask

  task automatic load_byte(int s, logic [7:0] d, logic last);
    @(negedge clk);
    drive_ld(s, d, last);
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(int s);
    @(negedge clk);
    if (s == 0) begin
      bus_a.ld_valid = 0; bus_a.ld_last = 0;
    end else begin
      bus_b.ld_valid = 0; bus_b.ld_last = 0;
    end
  endtask

  task automatic set_req(int s, logic r, logic [15:0] a);
    if (s == 0) begin
      bus_a.rd_req = r; bus_a.cxrom_addr = a;
    end else begin
      bus_b.rd_req = r; bus_b.cxrom_addr = a;
    end
  endtask

  task automatic push_exp(int s, logic [15:0] a);
    if (s == 0) exp_q0.push_back(exp_word(0, a));
    else exp_q1.push_back(exp_word(1, a));
  endtask

  // n counts edges from the accept edge through the ack edge
  task automatic fetch(int s, logic [15:0] a, output int n);
    @(negedge clk);
    set_req(s, 1'b1, a);
    push_exp(s, a);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack_of(s) && n < 20);
    @(negedge clk);
    set_req(s, 1'b0, a);
  endtask

  int n, n1, n2, acks0;

  initial begin
    rst = 1'b1;
    pc1_a = 0;
    pc1_b = 0;
    acks[0] = 0;
    acks[1] = 0;
    idle_inputs();
    do_reset();
    chk("rst_opv", 32'(op_valid_a), 0);

    // requests during load are ignored
    @(negedge clk);
    set_req(0, 1'b1, 16'h0000);
    repeat (5) @(negedge clk);
    set_req(0, 1'b0, 16'h0000);
    chk("noack_load", acks[0], 0);

    load_byte(0, 8'h15, 1'b0);
    pc1_a = 16'h0000;
    #1;
    chk("op_partial", 32'(op_out_a), 32'h15);
    chk("opv_partial", 32'(op_valid_a), 0);
    chk("loaded_partial", 32'(loaded_a), 0);
    load_byte(0, 8'hA8, 1'b1);
    chk("loaded_last", 32'(loaded_a), 1);
    chk("ld_ready_run", 32'(bus_a.ld_ready), 0);
    load_idle(0);
    load_byte(1, 8'h15, 1'b0);
    load_byte(1, 8'hA8, 1'b1);
    load_idle(1);

    fetch(0, 16'h0000, n);
    chk("lat_a", n - 1, 1);
    chk("data_a0", bus_a.cxrom_data_out, 32'h0000A815);

    pc1_a = 16'h0001;
    #1;
    chk("op_pc1", 32'(op_out_a), 32'hA8);
    chk("opv_run", 32'(op_valid_a), 1);
    pc1_a = 16'h0005;
    #1;
    chk("op_pc5", 32'(op_out_a), 32'h00);
    pc1_a = 16'h8000;
    #1;
    chk("op_oor", 32'(op_out_a), 32'h00);

    fetch(0, 16'hFFFF, n);
    chk("data_wrap", bus_a.cxrom_data_out, 32'h00A81500);

    // two held-request fetches on the wait-stated ROM
    @(negedge clk);
    set_req(1, 1'b1, 16'h0000);
    push_exp(1, 16'h0000);
    push_exp(1, 16'h0000);
    n = 0; n1 = 0; n2 = 0;
    while (n2 == 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus_b.rd_ack) begin
        if (n1 == 0) n1 = n;
        else n2 = n;
      end
    end
    @(negedge clk);
    set_req(1, 1'b0, 16'h0000);
    chk("lat_b", n1 - 1, 3);
    chk("gap_b", 32'((n2 - n1) >= 4), 1);

    load_byte(1, 8'hFF, 1'b0);
    chk("ld_ready_b", 32'(bus_b.ld_ready), 0);
    load_idle(1);
    fetch(1, 16'h0000, n);
    chk("lat_b2", n - 1, 3);

    // full 16-byte image without ld_last
    do_reset();
    for (int i = 0; i < 16; i++) begin
      load_byte(0, 8'(i), 1'b0);
      chk("loaded_stream", 32'(loaded_a), 32'(i == 15));
    end
    chk("ld_ready_full", 32'(bus_a.ld_ready), 0);
    load_byte(0, 8'hFF, 1'b0);
    load_idle(0);
    fetch(0, 16'h000C, n);
    chk("data_full", bus_a.cxrom_data_out, 32'h0F0E0D0C);
    fetch(0, 16'h000E, n);
    chk("data_edge", bus_a.cxrom_data_out, 32'h00000F0E);

    // last byte and request in the same cycle
    load_byte(1, 8'h21, 1'b0);
    @(negedge clk);
    drive_ld(1, 8'h22, 1'b1);
    set_req(1, 1'b1, 16'h0000);
    push_exp(1, 16'h0000);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus_b.ld_valid = 0;
        bus_b.ld_last = 0;
      end
    end while (!bus_b.rd_ack && n < 20);
    @(negedge clk);
    set_req(1, 1'b0, 16'h0000);
    chk("lat_last_b", n, 5);

    // reset while waiting aborts the fetch
    acks0 = acks[1];
    @(negedge clk);
    set_req(1, 1'b1, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 1'b0, 16'h0000);
    clear_model();
    repeat (2) begin
      @(negedge clk);
      chk("ack_in_rst", 32'(bus_b.rd_ack), 0);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("noack_abort", acks[1], acks0);
    chk("loaded_abort", 32'(loaded_b), 0);
    chk("opv_abort", 32'(op_valid_b), 0);
    for (int p = 0; p < 17; p++) begin
      pc1_b = 16'(p);
      #1;
      chk("op_fill", 32'(op_out_b), 32'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
